// File: rtl/adc_ovfl_mon_pkg.sv
// Shared constants for the ADC overflow monitor.
// Firmware mirrors these defaults so both sides agree on the window length.
package adc_ovfl_mon_pkg;

    localparam int CTR_BITS_DEF = 16;
    localparam int CNT_BITS_DEF = 16;

endpackage

// File: rtl/adc_ovfl_mon_if.sv
// Sample/statistics bundle between the ADC front end, the host and the monitor.
interface adc_ovfl_mon_if
    import adc_ovfl_mon_pkg::*;
#(
    parameter int CNT_BITS = CNT_BITS_DEF
);

    logic                adc_ovfl;
    logic [CNT_BITS-1:0] cnt_mask;
    logic                clr_stats;
    logic                ovfl_pulse;
    logic                win_done;
    logic [CNT_BITS-1:0] win_cnt;
    logic [CNT_BITS-1:0] peak_cnt;
    logic [CNT_BITS-1:0] run_max;

    modport master (
        output adc_ovfl, cnt_mask, clr_stats,
        input  ovfl_pulse, win_done, win_cnt, peak_cnt, run_max
    );

    modport slave (
        input  adc_ovfl, cnt_mask, clr_stats,
        output ovfl_pulse, win_done, win_cnt, peak_cnt, run_max
    );

endinterface

// File: rtl/adc_ovfl_mon_sat_ctr.sv
// Saturating counter with increment and synchronous clear.
// cnt_inc is the saturated cnt+inc, which the register reloads unless cleared.
module adc_ovfl_mon_sat_ctr
    import adc_ovfl_mon_pkg::*;
#(
    parameter int W = CNT_BITS_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt_inc
);

    logic [W-1:0] cnt;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v, input logic en);
        if (en && (v != '1)) begin
            return v + W'(1);
        end
        return v;
    endfunction

    assign cnt_inc = sat_inc(cnt, inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/adc_ovfl_mon.sv
// Windowed ADC overflow monitor: per-window overflow count, masked window-end
// pulse, and peak / longest-run statistics for host diagnostics.
module adc_ovfl_mon
    import adc_ovfl_mon_pkg::*;
#(
    parameter int CTR_BITS = CTR_BITS_DEF,
    parameter int CNT_BITS = CNT_BITS_DEF
) (
    input  logic           adc_clk,
    input  logic           rst_n,
    adc_ovfl_mon_if.slave  bus
);

    logic                ovfl_p0;
    logic [CTR_BITS-1:0] pos;
    logic                term;
    logic [CNT_BITS-1:0] acc_inc;
    logic [CNT_BITS-1:0] run_inc;
    logic [CNT_BITS-1:0] run_nxt;
    logic [CNT_BITS-1:0] peak_base;
    logic [CNT_BITS-1:0] run_max_base;
    logic [CNT_BITS-1:0] win_cnt_p1;
    logic [CNT_BITS-1:0] peak_p1;
    logic [CNT_BITS-1:0] run_max_p1;
    logic                ovfl_pulse_p1;
    logic                win_done_p1;

    function automatic logic [CNT_BITS-1:0] max_cnt(input logic [CNT_BITS-1:0] a,
                                                    input logic [CNT_BITS-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Stage 0: register the raw pin; everything downstream sees only ovfl_p0
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            ovfl_p0 <= 1'b0;
            pos     <= '0;
        end else begin
            ovfl_p0 <= bus.adc_ovfl;
            pos     <= pos + CTR_BITS'(1);
        end
    end

    // The all-ones position is the last sample of the window and still counts in it
    assign term = &pos;

    adc_ovfl_mon_sat_ctr #(.W(CNT_BITS)) u_acc (
        .clk     (adc_clk),
        .rst_n   (rst_n),
        .inc     (ovfl_p0),
        .clr     (term),
        .cnt_inc (acc_inc)
    );

    // Run length resets on any clean sample; it deliberately ignores window edges
    adc_ovfl_mon_sat_ctr #(.W(CNT_BITS)) u_run (
        .clk     (adc_clk),
        .rst_n   (rst_n),
        .inc     (ovfl_p0),
        .clr     (~ovfl_p0),
        .cnt_inc (run_inc)
    );

    assign run_nxt      = ovfl_p0 ? run_inc : '0;
    assign peak_base    = bus.clr_stats ? '0 : peak_p1;
    assign run_max_base = bus.clr_stats ? '0 : run_max_p1;

    // Stage 1: window-end results and statistics (clear first, then update)
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_p1    <= '0;
            peak_p1       <= '0;
            run_max_p1    <= '0;
            ovfl_pulse_p1 <= 1'b0;
            win_done_p1   <= 1'b0;
        end else begin
            win_done_p1   <= term;
            ovfl_pulse_p1 <= term && ((acc_inc & bus.cnt_mask) != '0);
            if (term) begin
                win_cnt_p1 <= acc_inc;
                peak_p1    <= max_cnt(peak_base, acc_inc);
            end else begin
                peak_p1    <= peak_base;
            end
            run_max_p1    <= max_cnt(run_max_base, run_nxt);
        end
    end

    assign bus.win_cnt    = win_cnt_p1;
    assign bus.peak_cnt   = peak_p1;
    assign bus.run_max    = run_max_p1;
    assign bus.ovfl_pulse = ovfl_pulse_p1;
    assign bus.win_done   = win_done_p1;

endmodule

// File: tb/tb_adc_ovfl_mon.sv
// Bench for adc_ovfl_mon with 16-sample windows and 4-bit counts: directed
// scenarios plus randomized traffic against a window/run reference model.
module tb_adc_ovfl_mon;

    localparam int CTR = 4;
    localparam int CNT = 4;
    localparam int WIN = 16;
    localparam int SAT = 15;

    logic adc_clk = 1'b0;
    logic rst_n   = 1'b1;
    int   n_chk   = 0;
    int   n_pass  = 0;
    bit   chk_en  = 1'b0;
    int   cyc;

    adc_ovfl_mon_if #(.CNT_BITS(CNT)) bus();

    adc_ovfl_mon #(.CTR_BITS(CTR), .CNT_BITS(CNT)) dut (
        .adc_clk (adc_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Reference model: a window is the last 16 registered samples; counts are plain sums
    int m_q, m_win_cnt, m_pulse, m_done, m_peak, m_run, m_run_max, m_sum;
    int m_samples[$];

    always @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q = 0; m_win_cnt = 0; m_pulse = 0; m_done = 0;
            m_peak = 0; m_run = 0; m_run_max = 0;
            m_samples.delete();
        end else begin
            m_samples.push_back(m_q);
            m_done  = 0;
            m_pulse = 0;
            if (bus.clr_stats) m_peak = 0;
            if (m_samples.size() == WIN) begin
                m_sum = 0;
                foreach (m_samples[k]) m_sum += m_samples[k];
                m_win_cnt = imin(m_sum, SAT);
                m_done    = 1;
                m_pulse   = ((m_win_cnt & int'(bus.cnt_mask)) != 0) ? 1 : 0;
                m_peak    = imax(m_peak, m_win_cnt);
                m_samples.delete();
            end
            m_run = (m_q != 0) ? m_run + 1 : 0;
            if (bus.clr_stats) m_run_max = 0;
            m_run_max = imax(m_run_max, imin(m_run, SAT));
            m_q = int'(bus.adc_ovfl);
        end
    end

    always @(negedge adc_clk) begin
        if (chk_en) begin
            chk("m_win_cnt",    int'(bus.win_cnt),    m_win_cnt);
            chk("m_ovfl_pulse", int'(bus.ovfl_pulse), m_pulse);
            chk("m_win_done",   int'(bus.win_done),   m_done);
            chk("m_peak_cnt",   int'(bus.peak_cnt),   m_peak);
            chk("m_run_max",    int'(bus.run_max),    m_run_max);
        end
    end

    task automatic cyc_drive(input logic b, input logic c);
        bus.adc_ovfl  = b;
        bus.clr_stats = c;
        @(negedge adc_clk);
    endtask

    task automatic align();
        while (((cyc + 1) % WIN) != 0) cyc_drive(1'b0, 1'b0);
    endtask

    // Drives one aligned window, then the terminal cycle (optionally with clr_stats)
    task automatic run_window(input logic [15:0] pat, input logic clr_term);
        align();
        for (int i = 0; i < WIN; i++) cyc_drive(pat[i], 1'b0);
        cyc_drive(1'b0, clr_term);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_win_cnt"},    int'(bus.win_cnt),    0);
        chk({tag, "_ovfl_pulse"}, int'(bus.ovfl_pulse), 0);
        chk({tag, "_win_done"},   int'(bus.win_done),   0);
        chk({tag, "_peak_cnt"},   int'(bus.peak_cnt),   0);
        chk({tag, "_run_max"},    int'(bus.run_max),    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone, npulse, wa, wb, bias;
        logic [31:0] pat32;
        logic b, c;

        bus.adc_ovfl  = 1'b0;
        bus.clr_stats = 1'b0;
        bus.cnt_mask  = 4'hF;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge adc_clk);
        chk_all_zero("rst");
        chk_en = 1'b1;
        #2 rst_n = 1'b1;

        // Idle: four full windows, no overflow
        ndone = 0; npulse = 0;
        for (int i = 0; i < 64; i++) begin
            cyc_drive(1'b0, 1'b0);
            ndone  += int'(bus.win_done);
            npulse += int'(bus.ovfl_pulse);
        end
        chk("idle_done_cnt", ndone, 4);
        chk("idle_pulse_cnt", npulse, 0);
        chk("idle_peak", int'(bus.peak_cnt), 0);
        chk("idle_run_max", int'(bus.run_max), 0);

        // Masked counting
        run_window(16'h0444, 1'b0);
        chk("mask_f_win_cnt", int'(bus.win_cnt), 3);
        chk("mask_f_pulse", int'(bus.ovfl_pulse), 1);
        chk("mask_f_done", int'(bus.win_done), 1);
        bus.cnt_mask = 4'h8;
        run_window(16'h0444, 1'b0);
        chk("mask_8_win_cnt", int'(bus.win_cnt), 3);
        chk("mask_8_pulse", int'(bus.ovfl_pulse), 0);
        bus.cnt_mask = 4'hF;

        // Saturation and terminal sample
        run_window(16'hFFFF, 1'b0);
        chk("sat_win_cnt", int'(bus.win_cnt), 15);
        chk("sat_peak", int'(bus.peak_cnt), 15);
        chk("sat_run_max", int'(bus.run_max), 15);
        run_window(16'h8000, 1'b0);
        chk("term_win_cnt", int'(bus.win_cnt), 1);
        chk("term_pulse", int'(bus.ovfl_pulse), 1);

        // Run of 6 crossing a window boundary
        cyc_drive(1'b0, 1'b1);
        chk("clr_peak", int'(bus.peak_cnt), 0);
        chk("clr_run_max", int'(bus.run_max), 0);
        align();
        pat32 = 32'h0007_E000;
        wa = -1;
        for (int i = 0; i < 32; i++) begin
            cyc_drive(pat32[i], 1'b0);
            if (i == 16) wa = int'(bus.win_cnt);
        end
        cyc_drive(1'b0, 1'b0);
        wb = int'(bus.win_cnt);
        chk("span_run_max", int'(bus.run_max), 6);
        chk("span_win_sum", wa + wb, 6);
        chk("span_win_a", wa, 3);

        // Clear coincident with window end
        run_window(16'h01FF, 1'b0);
        chk("pre_clr_peak", int'(bus.peak_cnt), 9);
        run_window(16'h0101, 1'b1);
        chk("clr_term_win_cnt", int'(bus.win_cnt), 2);
        chk("clr_term_peak", int'(bus.peak_cnt), 2);
        chk("clr_term_run_max", int'(bus.run_max), 0);

        // Reset mid-window
        align();
        for (int i = 0; i < 5; i++) cyc_drive(1'b1, 1'b0);
        bus.adc_ovfl = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge adc_clk);
        @(negedge adc_clk);
        #2 rst_n = 1'b1;
        ndone = 0; npulse = 0;
        for (int i = 0; i < WIN; i++) begin
            cyc_drive(1'b0, 1'b0);
            ndone  += int'(bus.win_done);
            npulse += int'(bus.ovfl_pulse);
        end
        chk("midrst_pulse_cnt", npulse, 0);
        chk("midrst_done_cnt", ndone, 1);
        chk("midrst_done_last", int'(bus.win_done), 1);
        chk("midrst_win_cnt", int'(bus.win_cnt), 0);

        // Randomized traffic with one reset in the middle
        bias = 50;
        for (int i = 0; i < 900; i++) begin
            if ((i % 100) == 0) bias = $urandom_range(0, 2) * 45 + 5;
            if (((cyc + 1) % WIN) == 1) bus.cnt_mask = 4'($urandom_range(0, 15));
            b = ($urandom_range(0, 99) < bias);
            c = ($urandom_range(0, 39) == 0);
            cyc_drive(b, c);
            if (i == 450) begin
                #2 rst_n = 1'b0;
                @(negedge adc_clk);
                #2 rst_n = 1'b1;
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adc_ovfl_mon.md
# adc_ovfl_mon

Windowed ADC overflow monitor on the `adc_clk` domain, between the ADC input register and the `SYNC_PULSE` that carries overflow into the `cpu_clk` domain.
- Counts asserted `ADC_OVFL` samples over fixed windows of 2^CTR_BITS samples.
- Emits a one-cycle overflow pulse when the masked window count is non-zero.
- Keeps last-window, peak-window and longest-consecutive-run statistics for host diagnostics.

## Interface
Parameters:
- `CTR_BITS`, 16: window length is 2^CTR_BITS adc_clk samples.
- `CNT_BITS`, 16: width of all count outputs. Counts saturate at 2^CNT_BITS-1.

Ports:
- `adc_clk` in 1: sole clock, ADC sample clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `adc_ovfl` in 1: raw ADC overflow pin, one sample per cycle.
- `cnt_mask` in CNT_BITS: quasi-static mask, already synchronised by the caller. Only changed between windows; no glitch guarantee otherwise.
- `clr_stats` in 1: single-cycle pulse; clears peak and run statistics.
- `ovfl_pulse` out 1: one-cycle pulse at window end if (window count & cnt_mask) != 0.
- `win_done` out 1: one-cycle pulse at every window end.
- `win_cnt` out CNT_BITS: overflow count of the last completed window.
- `peak_cnt` out CNT_BITS: maximum `win_cnt` since reset or `clr_stats`.
- `run_max` out CNT_BITS: longest run of consecutive overflow samples since reset or `clr_stats`.

## Operation
- **Input stage:** `adc_ovfl` is registered once into `ovfl_q`. All logic uses `ovfl_q` only.
- **Window counter `pos`** (CTR_BITS wide):
  - Increments every cycle and wraps from all-ones to 0.
  - The cycle with `pos` = all-ones is the terminal sample; it is counted in the closing window.
- **Accumulator `acc`:**
  - On non-terminal cycles: `acc` <= sat(`acc` + `ovfl_q`).
  - On the terminal cycle: `win_cnt` <= sat(`acc` + `ovfl_q`), then `acc` <= 0.
  - Saturation means no wrap at 2^CNT_BITS-1. This matters when CTR_BITS >= CNT_BITS.
- **Window-end outputs**, on the terminal cycle:
  - `ovfl_pulse` <= ((new `win_cnt` & `cnt_mask`) != 0).
  - `win_done` <= 1.
  - Both drop to 0 on every other cycle.
- **Peak:** on the terminal cycle, `peak_cnt` <= max(`peak_cnt`, new `win_cnt`).
- **Run tracking:**
  - `run` <= `ovfl_q` ? sat(`run`+1) : 0.
  - `run_max` <= max(`run_max`, next `run`) every cycle.
  - Runs span window boundaries and are not reset at window end.
- **`clr_stats`:**
  - `peak_cnt` <= 0 and `run_max` <= 0. `run` itself is not cleared.
  - If it coincides with the terminal cycle, `peak_cnt` <= new `win_cnt`: clear, then update in the same cycle.
  - If it coincides with a cycle where `ovfl_q`=1, `run_max` <= next `run`.
  - Does not affect `pos`, `acc`, `win_cnt` or the pulses.
- **Reset:** all registers go to 0, including `ovfl_q`, `pos`, `acc`, `run` and every output. The first window after reset release is a full 2^CTR_BITS samples.

## Timing
- `adc_ovfl` to `ovfl_q`: 1 cycle.
- `ovfl_q` on the terminal cycle to `win_cnt`, `ovfl_pulse`, `win_done` and `peak_cnt`: visible 1 cycle later (registered).
- `run_max` reflects an `ovfl_q` sample 1 cycle later.
- `ovfl_pulse` and `win_done` are exactly 1 cycle wide and separated by 2^CTR_BITS cycles. The downstream `SYNC_PULSE` handles the domain crossing.
- Asserting `rst_n` mid-window aborts the window with no pulse. Outputs go to 0 immediately (asynchronously).
- Deassertion of `rst_n` is synchronised externally; the block assumes release is clean.

## Structure
- Define the saturating increment and the max-compare as local functions.
- Put default `CTR_BITS`/`CNT_BITS` constants in the shared `kiwi.gen.vh` constant set, so firmware and RTL agree on window length.
- One natural sub-module: `sat_ctr`, a CNT_BITS saturating counter with increment and synchronous clear. It is instantiated for `acc` and for `run`.

## Test plan
Use CTR_BITS=4 (16-sample window) and CNT_BITS=4 in these scenarios unless noted.
1. **Reset and idle:** `rst_n` low, then high, with `adc_ovfl`=0 for 64 cycles → `win_done` pulses every 16 cycles; `ovfl_pulse`, `win_cnt`, `peak_cnt` and `run_max` all remain 0.
2. **Masked counting:** 3 isolated overflow samples in one window, first with `cnt_mask`=4'hF, then with 4'h8 → `win_cnt`=3 and `ovfl_pulse`=1 with mask 4'hF; `ovfl_pulse`=0 with mask 4'h8.
3. **Saturation and terminal sample:** `adc_ovfl`=1 for 16 samples (CNT_BITS=4) → `win_cnt`=15, not 0, and `peak_cnt`=15. Also, a single overflow placed on the terminal sample only → `win_cnt`=1.
4. **Run spanning a window boundary:** a run of 6 consecutive overflows crossing the window boundary → `run_max`=6; the two `win_cnt` values sum to 6.
5. **Clear coincident with window end:** `clr_stats` on the terminal cycle of a window with count 2, after a prior peak of 9 → `peak_cnt`=2 and `run_max` cleared.
6. **Reset mid-window:** `rst_n` pulsed low after 5 overflow samples → no `ovfl_pulse`; the next full window with 0 overflows gives `win_cnt`=0.
